// File: rtl/ram_miso_serializer.sv
// Circular buffer of coded-bit groups (up to 6 bits each) drained one bit per
// cycle over a valid/ready link. Define RAM_MISO_MSB_FIRST_EN to emit each group MSB first.
module ram_miso_serializer #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     wen,
    input  logic [5:0]               data_i,
    input  logic [2:0]               nbits_i,
    output logic                     full_o,
    output logic                     wr_err_o,
    output logic                     bit_o,
    output logic                     bit_valid_o,
    input  logic                     bit_ready_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    // Each slot holds {nbits, data}
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [2:0]    r_bidx;
    logic [AW:0]   r_count;
    logic          r_wr_err;

    logic          w_full;
    logic          w_empty;
    logic          w_nbits_ok;
    logic          w_wr_ok;
    logic          w_wr_bad;
    logic [8:0]    w_head;
    logic [5:0]    w_head_data;
    logic [2:0]    w_head_nbits;
    logic [2:0]    w_last_idx;
    logic [2:0]    w_bit_pos;
    logic [5:0]    w_sel;
    logic          w_xfer;
    logic          w_pop;

    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_nbits_ok   = (nbits_i != 3'd0) && (nbits_i <= 3'd6);
    assign w_wr_ok      = wen & ~w_full & ~flush_i & w_nbits_ok;
    assign w_wr_bad     = wen & ~flush_i & (w_full | ~w_nbits_ok);

    assign w_head       = r_mem[r_rptr];
    assign w_head_data  = w_head[5:0];
    assign w_head_nbits = w_head[8:6];
    assign w_last_idx   = w_head_nbits - 3'd1;

`ifdef RAM_MISO_MSB_FIRST_EN
    assign w_bit_pos = w_last_idx - r_bidx;
`else
    assign w_bit_pos = r_bidx;
`endif

    for (genvar gi = 0; gi < 6; gi++) begin : g_sel
        assign w_sel[gi] = (w_bit_pos == 3'(gi)) & w_head_data[gi];
    end

    // A flush pre-empts any transfer so the downstream never sees a consumed bit vanish
    assign w_xfer = ~w_empty & bit_ready_i & ~flush_i;
    assign w_pop  = w_xfer & (r_bidx == w_last_idx);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= {nbits_i, data_i};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_bidx   <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else if (flush_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_bidx   <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_bad;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_xfer) begin
                if (w_pop) begin
                    r_bidx <= '0;
                    r_rptr <= r_rptr + AW'(1);
                end else begin
                    r_bidx <= r_bidx + 3'd1;
                end
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_count;
    assign wr_err_o    = r_wr_err;
    assign bit_valid_o = ~w_empty;
    assign bit_o       = ~w_empty & (|w_sel);

endmodule

// File: tb/tb_ram_miso_serializer.sv
// Randomized scoreboard bench for ram_miso_serializer; the reference model tracks
// slots and their bit stream as plain queues and follows RAM_MISO_MSB_FIRST_EN for bit order.
module tb_ram_miso_serializer;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush_i = 1'b0;
    logic          wen = 1'b0;
    logic [5:0]    data_i = '0;
    logic [2:0]    nbits_i = '0;
    logic          bit_ready_i = 1'b0;
    logic          full_o;
    logic          wr_err_o;
    logic          bit_o;
    logic          bit_valid_o;
    logic          empty_o;
    logic [AW:0]   count_o;

    ram_miso_serializer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .wen         (wen),
        .data_i      (data_i),
        .nbits_i     (nbits_i),
        .full_o      (full_o),
        .wr_err_o    (wr_err_o),
        .bit_o       (bit_o),
        .bit_valid_o (bit_valid_o),
        .bit_ready_i (bit_ready_i),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    ent_t m_bits[$];     // model bit stream, with end-of-slot markers
    logic exp_q[$];      // scoreboard of bits the DUT still owes
    int   m_count = 0;   // slots still holding untransferred bits
    logic m_err = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must deliver the oldest outstanding expected bit
    always @(negedge clk) begin
        if (rstn && bit_valid_o && bit_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bit: got bit %0d with nothing expected at %0t", bit_o, $time);
            end else begin
                chk("serial_bit", int'(bit_o), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state();
        chk("count", int'(count_o), m_count);
        chk("empty", int'(empty_o), int'(m_count == 0));
        chk("full", int'(full_o), int'(m_count == DEPTH));
        chk("valid", int'(bit_valid_o), int'(m_bits.size() != 0));
        chk("wr_err", int'(wr_err_o), int'(m_err));
        if (m_bits.size() == 0) begin
            chk("bit_idle", int'(bit_o), 0);
        end
    endtask

    task automatic model_update();
        int   pre;
        logic ne;
        ent_t e;
        int   idx;
        pre   = m_count;
        ne    = (m_bits.size() != 0);
        m_err = 1'b0;
        if (flush_i) begin
            m_bits.delete();
            exp_q.delete();
            m_count = 0;
            $display("flush");
        end else begin
            if (ne && bit_ready_i) begin
                e = m_bits.pop_front();
                if (e.last) m_count--;
            end
            if (wen) begin
                if (pre == DEPTH || nbits_i == 3'd0 || nbits_i > 3'd6) begin
                    m_err = 1'b1;
                    $display("write data=%b nbits=%0d rejected (count %0d)", data_i, nbits_i, pre);
                end else begin
                    for (int k = 0; k < int'(nbits_i); k++) begin
`ifdef RAM_MISO_MSB_FIRST_EN
                        idx = int'(nbits_i) - 1 - k;
`else
                        idx = k;
`endif
                        e.b    = data_i[idx];
                        e.last = (k == int'(nbits_i) - 1);
                        m_bits.push_back(e);
                        exp_q.push_back(e.b);
                    end
                    m_count++;
                    $display("write data=%b nbits=%0d accepted (count %0d)", data_i, nbits_i, m_count);
                end
            end
        end
    endtask

    task automatic step(input logic w, input logic [5:0] d, input logic [2:0] n,
                        input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        check_state();
        wen         = w;
        data_i      = d;
        nbits_i     = n;
        bit_ready_i = rdy;
        flush_i     = fl;
        model_update();
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) step(1'b0, 6'd0, 3'd0, rdy, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 2000;
        while (m_count != 0 && budget > 0) begin
            step(1'b0, 6'd0, 3'd0, 1'b1, 1'b0);
            budget--;
        end
        step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
        chk("drain_done", m_count, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic reset_mid_stream();
        @(posedge clk);
        #2;
        rstn        = 1'b0;
        wen         = 1'b0;
        flush_i     = 1'b0;
        bit_ready_i = 1'b0;
        #1;
        chk("rst_valid", int'(bit_valid_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_bit", int'(bit_o), 0);
        chk("rst_err", int'(wr_err_o), 0);
        m_bits.delete();
        exp_q.delete();
        m_count = 0;
        m_err   = 1'b0;
        $display("async reset asserted");
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        logic       rw;
        logic [5:0] rd;
        logic [2:0] rn;
        logic       rr;
        logic       rf;

        repeat (2) @(posedge clk);
        #1;
        chk("init_count", int'(count_o), 0);
        chk("init_empty", int'(empty_o), 1);
        chk("init_valid", int'(bit_valid_o), 0);
        chk("init_bit", int'(bit_o), 0);
        chk("init_err", int'(wr_err_o), 0);
        #1;
        rstn = 1'b1;

        // single six-bit group
        step(1'b1, 6'b101101, 3'd6, 1'b1, 1'b0);
        idle(8, 1'b1);

        // back-to-back short groups must stream without gaps
        step(1'b1, 6'b000001, 3'd1, 1'b1, 1'b0);
        step(1'b1, 6'b000010, 3'd2, 1'b1, 1'b0);
        step(1'b1, 6'b000110, 3'd4, 1'b1, 1'b0);
        idle(9, 1'b1);

        // fill to full, overflow, then write while popping at full
        step(1'b1, 6'($urandom), 3'd1, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b1, 6'($urandom), 3'($urandom_range(1, 6)), 1'b0, 1'b0);
        end
        step(1'b1, 6'b111111, 3'd3, 1'b0, 1'b0);
        step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 6'b010101, 3'd2, 1'b1, 1'b0);
        idle(2, 1'b0);
        drain();

        // illegal group lengths
        step(1'b1, 6'b001100, 3'd3, 1'b0, 1'b0);
        step(1'b1, 6'b111111, 3'd0, 1'b0, 1'b0);
        step(1'b1, 6'b111111, 3'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        drain();

        // reset in the middle of a slot
        step(1'b1, 6'b110101, 3'd6, 1'b0, 1'b0);
        idle(3, 1'b1);
        reset_mid_stream();
        idle(2, 1'b1);

        // flush wins over a concurrent write
        step(1'b1, 6'($urandom), 3'd3, 1'b0, 1'b0);
        step(1'b1, 6'($urandom), 3'd5, 1'b0, 1'b0);
        step(1'b1, 6'($urandom), 3'd4, 1'b1, 1'b1);
        idle(2, 1'b1);

        // bit-order directed case
        step(1'b1, 6'b000011, 3'd4, 1'b1, 1'b0);
        idle(5, 1'b1);

        // steady write+pop, wrapping both pointers twice
        for (int i = 0; i < 140; i++) begin
            step(1'b1, 6'($urandom), 3'd1, 1'b1, 1'b0);
        end
        drain();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rw = 1'($urandom_range(0, 1));
            rd = 6'($urandom);
            rn = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
            rr = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 149) == 0);
            step(rw, rd, rn, rr, rf);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_miso_serializer.md
RAM_MISO_SERIALIZER -- requirements
Module: ram_miso_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of word slots (power of two, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  synchronous clear of all buffered content.
REQ-005 SHALL have port wen  input  1  write strobe for one coded-bit group.
REQ-006 SHALL have port data_i  input  6  coded-bit group; bit 0 is the first bit in LSB-first order.
REQ-007 SHALL have port nbits_i  input  3  number of valid bits in data_i, legal 1..6.
REQ-008 SHALL have port full_o  output  1  high when all DEPTH slots are occupied.
REQ-009 SHALL have port wr_err_o  output  1  one-cycle pulse on a rejected write.
REQ-010 SHALL have port bit_o  output  1  current serial bit.
REQ-011 SHALL have port bit_valid_o  output  1  bit_o is valid.
REQ-012 SHALL have port bit_ready_i  input  1  downstream accepts bit_o.
REQ-013 SHALL have port empty_o  output  1  high when no slot is occupied.
REQ-014 SHALL have port count_o  output  $clog2(DEPTH)+1  number of occupied slots.

Function
REQ-015 SHALL store each accepted write (6 data bits + 3-bit nbits) in a circular buffer at write pointer, then increment the pointer modulo DEPTH.
REQ-016 SHALL accept a write only when wen=1, full_o=0, flush_i=0 and 1<=nbits_i<=6.
REQ-017 SHALL drop a write with wen=1 and (full_o=1 or nbits_i=0 or nbits_i>6) and pulse wr_err_o high the following cycle; buffer unchanged.
REQ-018 SHALL evaluate full_o on the pre-edge count: a write while full is rejected even if a slot is popped in the same cycle.
REQ-019 SHALL assert bit_valid_o whenever empty_o=0; bit_o SHALL be combinational from the head slot and bit index register.
REQ-020 SHALL raise bit_valid_o the cycle after an accepted write into an empty buffer (one-cycle write-to-valid latency).
REQ-021 SHALL hold bit_o stable while bit_valid_o=1 and bit_ready_i=0.
REQ-022 SHALL advance the bit index on bit_valid_o & bit_ready_i; on transfer of the last bit (index = nbits-1) SHALL reset the index to 0 and increment the read pointer modulo DEPTH.
REQ-023 SHALL sustain one bit per cycle across slot boundaries with no bubble while slots remain.
REQ-024 SHALL, on simultaneous accepted write and slot pop, leave count_o unchanged.
REQ-025 SHALL, when flush_i=1, clear pointers, bit index and count at the next edge; flush_i has priority over wen and over a pop.
REQ-026 SHALL drive bit_o=0 when empty_o=1.
REQ-027 SHALL wrap both pointers from DEPTH-1 to 0 without loss.

Reset
REQ-028 SHALL on rstn=0 immediately clear pointers, bit index, count and wr_err_o; full_o=0, empty_o=1, bit_valid_o=0, bit_o=0, count_o=0.
REQ-029 SHALL discard buffered data on reset mid-stream; slot storage contents need not be cleared.
REQ-030 SHALL release from reset on rising rstn with first write accepted on the next clock edge.

Configuration
REQ-031 SHALL support macro RAM_MISO_MSB_FIRST_EN: when defined, bits of each slot are emitted from bit nbits-1 down to bit 0.
REQ-032 SHALL, without RAM_MISO_MSB_FIRST_EN, emit bits from bit 0 up to bit nbits-1 (LSB first).
REQ-033 SHALL keep interface, latency and all other behaviour identical in both configurations.

Verification
REQ-034 SHALL cover: write data_i=6'b101101,nbits=6 into empty, bit_ready_i=1 -> bit_valid_o next cycle, bit_o sequence 1,0,1,1,0,1 (LSB-first), then empty_o=1.
REQ-035 SHALL cover: writes nbits=1 (1), 2 (2'b10), 4 (4'b0110) back-to-back, ready held -> 7 contiguous bits 1,0,1,0,1,1,0 with no gap.
REQ-036 SHALL cover: fill 64 slots with ready=0 -> full_o=1, count_o=64; 65th write -> wr_err_o pulse, count_o stays 64; same-cycle pop+write at full -> write rejected, count_o=63.
REQ-037 SHALL cover: nbits_i=0 and nbits_i=7 writes -> wr_err_o pulse each, count_o unchanged.
REQ-038 SHALL cover: rstn low mid-slot (3 of 6 bits sent) -> bit_valid_o=0, count_o=0 asynchronously; flush_i with concurrent wen -> buffer empty next cycle.
REQ-039 SHALL cover: with RAM_MISO_MSB_FIRST_EN, data_i=6'b000011,nbits=4 -> bit_o sequence 0,0,1,1; 130 write/pop cycles verify pointer wrap.
